// File: rtl/fsm_serial_rx_pkg.sv
// Shared types and helpers for the parametrised serial frame receiver.
package fsm_serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Widest data word the receiver supports; narrower words are zero-extended.
  localparam int PAR_MAX_W = 16;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_shift_capture.sv
// LSB-first shift register plus a hold register loaded on a good frame.
// Parity build (FSM_SERIAL_RX_PARITY_EN) also exports the XOR of the shifted word.
module serial_shift_capture
  import fsm_serial_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              load,
  output logic [DATA_W-1:0] hold_dat
`ifdef FSM_SERIAL_RX_PARITY_EN
  , output logic            data_xor
`endif
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    shift_d = shift_q;
    hold_d  = hold_q;
    // New bits enter at the top so the first bit received ends up in bit 0.
    if (shift_en) begin
      shift_d = {bit_in, shift_q[DATA_W-1:1]};
    end
    if (load) begin
      hold_d = shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      hold_q  <= '0;
    end else begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
    end
  end

  assign hold_dat = hold_q;

`ifdef FSM_SERIAL_RX_PARITY_EN
  assign data_xor = parity_of(PAR_MAX_W'(shift_q));
`endif

endmodule

// File: rtl/fsm_serial_rx_param.sv
// Bit-serial frame receiver: start, DATA_W data bits LSB first, optional parity
// (FSM_SERIAL_RX_PARITY_EN), STOP_BITS stop bits; done pulses the cycle after the last stop bit.
module fsm_serial_rx_param
  import fsm_serial_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] out_byte,
  output logic              done,
  output logic              err_frame,
  output logic              err_parity,
  output logic              busy
);

  if (DATA_W < 5 || DATA_W > PAR_MAX_W || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("fsm_serial_rx_param: illegal parameter combination");
  end

  localparam int              CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               done_q, done_d;
  logic               err_frame_q, err_frame_d;
  logic               busy_q, busy_d;
  logic               shift_en;
  logic               load;

`ifdef FSM_SERIAL_RX_PARITY_EN
  localparam logic ODD_SENSE = (PARITY_ODD != 0);
  logic par_bad_q, par_bad_d;
  logic err_parity_q, err_parity_d;
  logic data_xor;
`endif

  serial_shift_capture #(
    .DATA_W   (DATA_W)
  ) u_capture (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .bit_in   (in),
    .load     (load),
    .hold_dat (out_byte)
`ifdef FSM_SERIAL_RX_PARITY_EN
    , .data_xor (data_xor)
`endif
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    done_d      = 1'b0;
    err_frame_d = 1'b0;
    shift_en    = 1'b0;
    load        = 1'b0;
`ifdef FSM_SERIAL_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    err_parity_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (in == LINE_START) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        shift_en  = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          stop_cnt_d = 1'b0;
`ifdef FSM_SERIAL_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FSM_SERIAL_RX_PARITY_EN
      PARITY: begin
        par_bad_d = data_xor ^ in ^ ODD_SENSE;
        state_d   = STOP;
      end
`endif
      STOP: begin
        // A low stop bit always wins over a parity complaint.
        if (in != LINE_IDLE) begin
          state_d     = ERR;
          err_frame_d = 1'b1;
        end else if (stop_cnt_q != LAST_STOP) begin
          stop_cnt_d = 1'b1;
`ifdef FSM_SERIAL_RX_PARITY_EN
        end else if (par_bad_q) begin
          state_d      = IDLE;
          err_parity_d = 1'b1;
`endif
        end else begin
          state_d = DONE;
          load    = 1'b1;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (in == LINE_START) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        if (in == LINE_IDLE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DATA) || (state_d == PARITY) || (state_d == STOP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      done_q      <= 1'b0;
      err_frame_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FSM_SERIAL_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      err_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      done_q      <= done_d;
      err_frame_q <= err_frame_d;
      busy_q      <= busy_d;
`ifdef FSM_SERIAL_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      err_parity_q <= err_parity_d;
`endif
    end
  end

  assign done      = done_q;
  assign err_frame = err_frame_q;
  assign busy      = busy_q;

`ifdef FSM_SERIAL_RX_PARITY_EN
  assign err_parity = err_parity_q;
`else
  assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_serial_rx_param.sv
// Frame-level checking of two receiver instances (8 data/1 stop and 7 data/2 stop).
module tb_fsm_serial_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in0, in1;
  logic [7:0] ob0;
  logic [6:0] ob1;
  logic       dn0, dn1, ef0, ef1, ep0, ep1, bs0, bs1;

  int checks = 0;
  int errors = 0;

`ifdef FSM_SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam logic ODD = 1'b0;

  logic [15:0] last_good [2];

  fsm_serial_rx_param #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .in(in0), .out_byte(ob0), .done(dn0),
    .err_frame(ef0), .err_parity(ep0), .busy(bs0)
  );

  fsm_serial_rx_param #(.DATA_W(7), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .in(in1), .out_byte(ob1), .done(dn1),
    .err_frame(ef1), .err_parity(ep1), .busy(bs1)
  );

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 7;
  endfunction

  function automatic int stp(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k, input logic b);
    if (k == 0) in0 = b; else in1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input int k, input string tag, input logic d, input logic f,
                           input logic p, input logic b);
    chk($sformatf("%s.done%0d", tag, k),  16'(k == 0 ? dn0 : dn1), 16'(d));
    chk($sformatf("%s.ferr%0d", tag, k),  16'(k == 0 ? ef0 : ef1), 16'(f));
    chk($sformatf("%s.perr%0d", tag, k),  16'(k == 0 ? ep0 : ep1), 16'(p));
    chk($sformatf("%s.busy%0d", tag, k),  16'(k == 0 ? bs0 : bs1), 16'(b));
    chk($sformatf("%s.out%0d", tag, k),
        (k == 0) ? {8'h00, ob0} : {9'h000, ob1}, last_good[k]);
  endtask

  task automatic idle(input int k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(k, 1'b1);
      check_out(k, tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Drives one whole frame; bad_stop selects a stop bit sent as 0 (-1 for none).
  task automatic send_frame(input int k, input logic [15:0] data_in, input bit par_flip,
                            input int bad_stop, input string tag);
    int w, s, n, si;
    logic [15:0] mask, data;
    logic b;
    bit is_stop, last, e_f, e_p, e_d;
    w    = wid(k);
    s    = stp(k);
    n    = 1 + w + P + s;
    mask = 16'((1 << w) - 1);
    data = data_in & mask;
    for (int j = 0; j < n; j++) begin
      is_stop = (j >= 1 + w + P);
      si      = j - (1 + w + P);
      if (j == 0)        b = 1'b0;
      else if (j <= w)   b = data[j-1];
      else if (!is_stop) b = (^data) ^ ODD ^ par_flip;
      else               b = (si == bad_stop) ? 1'b0 : 1'b1;
      step(k, b);
      e_f  = is_stop && !b;
      last = is_stop && b && (si == s - 1);
      e_p  = last && par_flip && (P == 1);
      e_d  = last && !e_p;
      if (e_d) last_good[k] = data;
      check_out(k, tag, e_d, e_f, e_p, !(e_f || last));
      if (e_f) break;
    end
    if (bad_stop >= 0 && bad_stop < s) begin
      step(k, 1'b0);
      check_out(k, {tag, "_errhold"}, 1'b0, 1'b0, 1'b0, 1'b0);
      step(k, 1'b0);
      check_out(k, {tag, "_errhold"}, 1'b0, 1'b0, 1'b0, 1'b0);
      step(k, 1'b1);
      check_out(k, {tag, "_erridle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] pat;
    reset = 1'b1;
    in0   = 1'b1;
    in1   = 1'b1;
    last_good[0] = '0;
    last_good[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out(0, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out(1, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(0, 2, "idle");

    send_frame(0, 16'h5A, 1'b0, -1, "f5a");
    idle(0, 2, "post5a");
    send_frame(0, 16'hA5, 1'b0, -1, "b2b_a5");
    send_frame(0, 16'h3C, 1'b0, -1, "b2b_3c");
    idle(0, 2, "post3c");
    send_frame(0, 16'h81, 1'b0, 0, "stop0_81");
    idle(0, 1, "post81");

    send_frame(1, 16'h55, 1'b0, 1, "w7_stop2bad");
    idle(1, 1, "w7_gap");
    send_frame(1, 16'h55, 1'b0, -1, "w7_good");
    idle(1, 2, "w7_post");

`ifdef FSM_SERIAL_RX_PARITY_EN
    send_frame(0, 16'h03, 1'b0, -1, "par_ok");
    idle(0, 1, "par_gap");
    send_frame(0, 16'h03, 1'b1, -1, "par_bad");
    idle(0, 1, "par_post");
`endif

    // Abort a frame partway through the data bits with reset.
    pat = 16'h5A;
    step(0, 1'b0);
    check_out(0, "rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step(0, pat[j]);
      check_out(0, "rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    step(0, 1'b1);
    last_good[0] = '0;
    last_good[1] = '0;
    check_out(0, "rst_hit", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out(1, "rst_hit", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(0, 1, "rst_rel");
    send_frame(0, 16'hFF, 1'b0, -1, "after_rst_ff");
    idle(0, 1, "after_rst_gap");

    for (int it = 0; it < 60; it++) begin
      int k, r, bad;
      bit flip;
      k    = int'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      bad  = (r < 2) ? int'($urandom_range(0, stp(k) - 1)) : -1;
      flip = (r == 2 || r == 3);
      send_frame(k, 16'($urandom), flip, bad, $sformatf("rnd%0d", it));
      idle(k, int'($urandom_range(0, 2)), "rnd_gap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_serial_rx_param.md
Name: fsm_serial_rx_param

Overview:
- Parametrised bit-serial frame receiver; one line bit is sampled per clock (no oversampling).
- Frame format: start bit (0), DATA_W data bits (LSB first), optional parity bit, STOP_BITS stop bits (1). The idle line is 1.
- Successor to the fixed 8-bit serial-data FSM. Adds configurable width and stop-bit count, a registered held output, error pulses and a busy flag.
- Sits between an external serial pin (already synchronised) and byte-oriented consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 5..16.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- in  input  1  serial line, sampled every rising clk edge.
- out_byte  output  DATA_W  data of the last good frame; held until the next good frame.
- done  output  1  one-cycle pulse: good frame received, out_byte updated.
- err_frame  output  1  one-cycle pulse: a stop bit was sampled as 0.
- err_parity  output  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- busy  output  1  high while in DATA, PARITY or STOP.

Behaviour:
- Reset state and values: state = IDLE, bit_cnt = 0, shift register = 0, out_byte = 0, done = err_frame = err_parity = busy = 0.
- Reset mid-frame returns to IDLE on the same edge. The partial frame is discarded and no pulses are emitted.
- IDLE: in = 0 means the start bit is consumed; go to DATA with bit_cnt = 0. in = 1 stays in IDLE.
- DATA: each edge shifts in into shift[DATA_W-1] (right shift, so bit 0 is received first) and increments bit_cnt.
  - After the DATA_W-th bit: go to PARITY if compiled in, else to STOP with stop_cnt = 0.
- PARITY: sample in and store par_bad = (XOR of data bits ^ in ^ PARITY_ODD). Go to STOP.
- STOP: sample in.
  - in = 0: go to ERR. err_frame pulses in the next cycle (registered on ERR entry).
  - in = 1 and more stop bits remain: stay in STOP and increment stop_cnt.
  - in = 1 on the last stop bit, par_bad = 0: go to DONE. out_byte <= shift on that same edge.
  - in = 1 on the last stop bit, par_bad = 1: go to IDLE. err_parity pulses the next cycle; out_byte is unchanged.
- DONE (one cycle): done = 1.
  - in = 0 is the start bit of a back-to-back frame; go straight to DATA.
  - in = 1 goes to IDLE.
- ERR: stay until in = 1, then go to IDLE. err_frame pulses only on the first ERR cycle.
- Latency: done rises in the cycle after the edge that samples the final stop bit. Minimum frame period is 1 + DATA_W + P + STOP_BITS cycles, where P = 1 with parity, else 0.
- Outputs done, err_frame, err_parity and busy are decoded from registered state/flags only; there is no combinational path from in.
- A 0 on the final stop bit always reports err_frame, never err_parity.
- bit_cnt width is $clog2(DATA_W+1).
- No X is ever driven on out_byte.

Optional Feature:
- Macro: FSM_SERIAL_RX_PARITY_EN.
- Defined: the PARITY state exists, the frame carries one parity bit after the data, and err_parity is live.
- Undefined: no parity bit in the frame, the PARITY state is removed, and err_parity is constant 0. The frame is start + DATA_W + STOP_BITS.

Decomposition:
- Package fsm_serial_rx_pkg holds:
  - the state enum typedef (IDLE, DATA, PARITY, STOP, DONE, ERR), 3 bits;
  - localparams for the idle line level (1) and start level (0);
  - a function for the parity XOR-reduce.
- One natural sub-module: serial_shift_capture, a DATA_W shift register with shift-enable and a load-to-hold output register. The FSM and counters stay in the top level.

Test Plan:
- DATA_W = 8, STOP_BITS = 1, no parity; send 0x5A (bits 0,1,0,1,1,0,1,0) framed -> done pulses once 10 cycles after the start bit edge, out_byte = 0x5A, no errors.
- Back-to-back frames 0xA5 then 0x3C with the second start bit in the DONE cycle -> two done pulses 10 cycles apart; out_byte = 0xA5, then 0x3C.
- Stop bit = 0 on a 0x81 frame -> err_frame pulses once, no done, out_byte keeps its previous value. The FSM holds in ERR while in = 0 and returns to IDLE on the first in = 1.
- DATA_W = 7, STOP_BITS = 2, second stop bit = 0 -> err_frame. The same frame 0x55 with both stop bits = 1 -> done, out_byte = 7'h55.
- With FSM_SERIAL_RX_PARITY_EN and PARITY_ODD = 0: 0x03 with parity 0 -> done. 0x03 with parity 1 -> err_parity pulse, no done, out_byte unchanged.
- Assert reset at DATA bit 4 -> IDLE next cycle, busy = 0, no pulses; the following clean 0xFF frame is received correctly.
